// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_sub_pkg;

  // Operand width used when the instantiating code does not override WIDTH.
  localparam int DEFAULT_WIDTH = 8;

  // Control states: waiting, processing one bit per cycle, result pulse.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: D = A - B - Bin, with borrow out.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the cell is always evaluated.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  // Difference bit and borrow generated by this bit position.
  always_comb begin
    D    = A ^ B ^ Bin;
    Bout = (~A & B) | (~A & Bin) | (B & Bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A-B (mod 2^WIDTH), LSB first; optional signed overflow output under SERIAL_SUB_OVF_EN.
// Latency: start accepted at cycle N -> busy N+1..N+WIDTH, done pulse at N+WIDTH+1.
// Backpressure: start ignored while busy; accepted in IDLE or DONE (back-to-back, no gap).
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t state_q;
  state_t state_d;

  logic load;
  logic step;
  logic last;

  // a_sr doubles as the result register: difference bits enter at the MSB
  // as minuend bits leave at the LSB.
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             borrow_q;
  logic [CNT_W-1:0] cnt_q;

  logic bit_d;
  logic bit_bout;

  full_subtractor u_cell (
    .A   (a_sr[0]),
    .B   (b_sr[0]),
    .Bin (borrow_q),
    .D   (bit_d),
    .Bout(bit_bout)
  );

  // State register; reset wins over any start request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode; status outputs come straight from state.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt_q == LAST_BIT) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand shift registers, inter-bit borrow and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else if (load) begin
      a_sr     <= A;
      b_sr     <= B;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else if (step) begin
      a_sr     <= {bit_d, a_sr[WIDTH-1:1]};
      b_sr     <= b_sr >> 1;
      borrow_q <= bit_bout;
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end

  // Result registers: loaded on the final bit (entry to DONE), held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      D    <= '0;
      Bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      Ovf  <= 1'b0;
`endif
    end else if (last) begin
      D    <= {bit_d, a_sr[WIDTH-1:1]};
      Bout <= bit_bout;
`ifdef SERIAL_SUB_OVF_EN
      // On the last bit a_sr[0]/b_sr[0] still hold the operand sign bits.
      Ovf  <= (a_sr[0] != b_sr[0]) && (bit_d != a_sr[0]);
`endif
    end
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL provide port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port start  input  1  request a subtraction; sampled only in IDLE or DONE.
REQ-005 SHALL provide port A  input  WIDTH  minuend, captured on accepted start.
REQ-006 SHALL provide port B  input  WIDTH  subtrahend, captured on accepted start.
REQ-007 SHALL provide port busy  output  1  high while bits are being processed.
REQ-008 SHALL provide port done  output  1  one-cycle pulse: result valid.
REQ-009 SHALL provide port D  output  WIDTH  registered difference A-B modulo 2^WIDTH.
REQ-010 SHALL provide port Bout  output  1  registered final borrow (1 when A<B unsigned).

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE; IDLE->SHIFT on start; SHIFT->DONE after WIDTH bit-cycles; DONE->SHIFT on start, else DONE->IDLE.
REQ-012 SHALL, on accepted start at cycle N, latch A and B into shift registers, clear borrow register and bit counter.
REQ-013 SHALL process one bit per SHIFT cycle, LSB first: d=a^b^bin, bnext=(~a&b)|(~a&bin)|(b&bin); borrow registered between bits.
REQ-014 SHALL occupy SHIFT for cycles N+1..N+WIDTH with busy=1, and be in DONE at cycle N+WIDTH+1 with done=1 for exactly that cycle.
REQ-015 SHALL update D and Bout on entry to DONE and hold them unchanged until the next completion.
REQ-016 SHALL ignore start while in SHIFT; operands and progress unaffected.
REQ-017 SHALL accept start asserted during DONE (back-to-back), entering SHIFT next cycle with no idle gap.
REQ-018 SHALL keep busy and done mutually exclusive; busy=0 in IDLE and DONE.
REQ-019 SHALL treat A==B as D=0, Bout=0; A=0,B=2^WIDTH-1 as D=1, Bout=1.

Reset
REQ-020 SHALL, when rst=1 at a clock edge, force state IDLE, busy=0, done=0, D=0, Bout=0, counter/borrow/shift registers 0.
REQ-021 SHALL abort any in-progress operation on reset with no done pulse and no D update; rst has priority over start.
REQ-022 SHALL accept start in the first cycle after rst deasserts.

Configuration
REQ-023 SHALL, with SERIAL_SUB_OVF_EN defined, add output Ovf 1 bit: signed two's-complement overflow, (A[msb]!=B[msb]) && (D[msb]!=A[msb]), updated/held/reset with D.
REQ-024 SHALL, without SERIAL_SUB_OVF_EN, omit the Ovf port and its logic entirely; all other behaviour identical.

Structure
REQ-025 SHALL place the FSM state enum (IDLE, SHIFT, DONE) and the default WIDTH constant in package serial_sub_pkg.
REQ-026 SHALL instantiate one combinational sub-module full_subtractor (ports A, B, Bin, D, Bout) for the per-bit cell.
REQ-027 SHALL size the bit counter as $clog2(WIDTH+1) bits.

Verification (WIDTH=8)
REQ-028 SHALL check A=0x05,B=0x03, start at cycle N -> done at N+9, D=0x02, Bout=0, busy high N+1..N+8.
REQ-029 SHALL check A=0x03,B=0x05 -> D=0xFE, Bout=1; A=0x00,B=0xFF -> D=0x01, Bout=1.
REQ-030 SHALL check with SERIAL_SUB_OVF_EN: A=0x80,B=0x01 -> D=0x7F, Ovf=1; A=0x10,B=0x01 -> D=0x0F, Ovf=0.
REQ-031 SHALL check start re-pulsed with new operands during SHIFT -> ignored, original result 0x02 delivered at N+9.
REQ-032 SHALL check rst at cycle N+4 -> busy=0 next cycle, no done, D retains reset value 0x00.
REQ-033 SHALL check start held high through DONE with A=0x0A,B=0x0A -> second done exactly 9 cycles after first, D=0x00, Bout=0.
